// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state encoding
// and the default operand width.
package div_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_ITER = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } div_state_t;

endpackage

// File: rtl/div_sequencer_if.sv
// Request/response bundle between a divider client (master) and div_sequencer (slave).
interface div_sequencer_if import div_pkg::*; #(
    parameter int WIDTH = DIV_WIDTH
) ();

    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, is_signed, dividend, divisor, flush,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, is_signed, dividend, divisor, flush,
        output busy, done, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// trial-subtract the divisor, keep or restore.
module div_step import div_pkg::*; #(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             dvd_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // rem_in < divisor holds between steps, so a restored remainder never
    // needs the extra top bit and a kept difference always fits WIDTH bits.
    always_comb begin
        shifted = {rem_in, dvd_bit};
        trial   = shifted - {1'b0, divisor};
        q_bit   = ~trial[WIDTH];
        rem_out = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle signed/unsigned divider: IDLE -> PREP -> ITER (WIDTH steps) -> FIX -> DONE,
// with a short PREP -> DONE path for division by zero and flush abort from any state.
module div_sequencer import div_pkg::*; #(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic            clk,
    input  logic            rst_n,
    div_sequencer_if.slave  bus
);

    localparam int              CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    div_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] quo_out_q, quo_out_d;
    logic [WIDTH-1:0] rem_out_q, rem_out_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             sgn_q, sgn_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;

    logic [WIDTH-1:0] step_rem;
    logic             step_bit;

    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v, input logic en);
        return (en && v[WIDTH-1]) ? -v : v;
    endfunction

    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic en);
        return en ? -v : v;
    endfunction

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_q),
        .dvd_bit (dvd_q[WIDTH-1]),
        .divisor (dsr_q),
        .rem_out (step_rem),
        .q_bit   (step_bit)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        quo_out_d = quo_out_q;
        rem_out_d = rem_out_q;
        dbz_d     = dbz_q;
        dvd_d     = dvd_q;
        dsr_d     = dsr_q;
        rem_d     = rem_q;
        sgn_d     = sgn_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    dvd_d   = bus.dividend;
                    dsr_d   = bus.divisor;
                    sgn_d   = bus.is_signed;
                    state_d = S_PREP;
                end
            end
            S_PREP: begin
                neg_quo_d = sgn_q & (dvd_q[WIDTH-1] ^ dsr_q[WIDTH-1]);
                neg_rem_d = sgn_q & dvd_q[WIDTH-1];
                if (dsr_q == '0) begin
                    quo_out_d = '1;
                    rem_out_d = dvd_q;
                    dbz_d     = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    dvd_d   = abs_val(dvd_q, sgn_q);
                    dsr_d   = abs_val(dsr_q, sgn_q);
                    rem_d   = '0;
                    cnt_d   = '0;
                    state_d = S_ITER;
                end
            end
            // dvd_q doubles as the quotient shift register: dividend bits leave at the top
            // while quotient bits enter at the bottom.
            S_ITER: begin
                rem_d = step_rem;
                dvd_d = {dvd_q[WIDTH-2:0], step_bit};
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_FIX: begin
                quo_out_d = cond_neg(dvd_q, neg_quo_q);
                rem_out_d = cond_neg(rem_q, neg_rem_q);
                dbz_d     = 1'b0;
                state_d   = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort wins over everything, including a result about to be published.
        if (bus.flush) begin
            state_d   = S_IDLE;
            cnt_d     = '0;
            quo_out_d = quo_out_q;
            rem_out_d = rem_out_q;
            dbz_d     = dbz_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            quo_out_q <= '0;
            rem_out_q <= '0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            quo_out_q <= quo_out_d;
            rem_out_q <= rem_out_d;
            dbz_q     <= dbz_d;
        end
    end

    // Working datapath needs no reset: PREP initialises it before any use.
    always_ff @(posedge clk) begin
        dvd_q     <= dvd_d;
        dsr_q     <= dsr_d;
        rem_q     <= rem_d;
        sgn_q     <= sgn_d;
        neg_quo_q <= neg_quo_d;
        neg_rem_q <= neg_rem_d;
    end

    assign bus.busy        = (state_q != S_IDLE);
    assign bus.done        = (state_q == S_DONE);
    assign bus.quotient    = quo_out_q;
    assign bus.remainder   = rem_out_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: directed corner cases plus randomized
// operations compared against an arithmetic reference model.
module tb_div_sequencer;

    localparam int W = 32;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;

    div_sequencer_if #(.WIDTH(W)) bus ();

    div_sequencer #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: plain arithmetic; signed case done in 64 bits so MIN/-1 wraps naturally.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         output logic [W-1:0] q, output logic [W-1:0] r, output logic dz);
        longint sa, sb, sq, sr;
        if (b == 0) begin
            q  = '1;
            r  = a;
            dz = 1'b1;
        end else if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            sq = sa / sb;
            sr = sa % sb;
            q  = sq[W-1:0];
            r  = sr[W-1:0];
            dz = 1'b0;
        end else begin
            q  = a / b;
            r  = a % b;
            dz = 1'b0;
        end
    endtask

    // Issues one operation; returns outputs at the done cycle, latency in edges
    // after the start edge (-1 on timeout), and state one cycle later.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         output logic [W-1:0] q, output logic [W-1:0] r, output logic dz,
                         output int lat, output logic busy_ok,
                         output logic done_after, output logic busy_after);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.is_signed = s;
        bus.dividend  = a;
        bus.divisor   = b;
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        bus.dividend = $urandom;
        bus.divisor  = $urandom;
        lat     = -1;
        busy_ok = 1'b1;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (!bus.busy) busy_ok = 1'b0;
            if (bus.done) begin
                lat = n;
                break;
            end
        end
        q  = bus.quotient;
        r  = bus.remainder;
        dz = bus.div_by_zero;
        @(posedge clk);
        #1;
        done_after = bus.done;
        busy_after = bus.busy;
    endtask

    task automatic test_reset();
        #12;
        tests_run++;
        if ({bus.busy, bus.done, bus.div_by_zero} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_flags: busy/done/dbz=%b expected 000", {bus.busy, bus.done, bus.div_by_zero});
        end
        tests_run++;
        if (bus.quotient !== '0 || bus.remainder !== '0) begin
            tests_failed++;
            $display("FAIL reset_data: q=%h r=%h expected 0 0", bus.quotient, bus.remainder);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_unsigned_basic();
        logic [W-1:0] q, r, eq, er;
        logic dz, edz, bok, da, ba;
        int lat;
        model(32'd100, 32'd7, 1'b0, eq, er, edz);
        do_op(32'd100, 32'd7, 1'b0, q, r, dz, lat, bok, da, ba);
        tests_run++;
        if (q !== eq || r !== er || dz !== edz) begin
            tests_failed++;
            $display("FAIL udiv_100_7: q=%0d r=%0d dz=%b expected q=%0d r=%0d dz=%b", q, r, dz, eq, er, edz);
        end
        tests_run++;
        if (lat !== W + 3) begin
            tests_failed++;
            $display("FAIL udiv_latency: got %0d expected %0d", lat, W + 3);
        end
        tests_run++;
        if (bok !== 1'b1) begin
            tests_failed++;
            $display("FAIL udiv_busy: busy dropped during operation, expected held high");
        end
        tests_run++;
        if (da !== 1'b0 || ba !== 1'b0) begin
            tests_failed++;
            $display("FAIL udiv_done_pulse: done=%b busy=%b after DONE, expected 0 0", da, ba);
        end
    endtask

    task automatic test_signed_modes();
        logic [W-1:0] q, r, eq, er;
        logic dz, edz, bok, da, ba;
        int lat;
        model(32'hFFFF_FFF9, 32'd2, 1'b1, eq, er, edz);
        do_op(32'hFFFF_FFF9, 32'd2, 1'b1, q, r, dz, lat, bok, da, ba);
        tests_run++;
        if (q !== eq || r !== er || dz !== edz || lat !== W + 3) begin
            tests_failed++;
            $display("FAIL sdiv_m7_2: q=%h r=%h dz=%b lat=%0d expected q=%h r=%h dz=%b lat=%0d",
                     q, r, dz, lat, eq, er, edz, W + 3);
        end
        model(32'hFFFF_FFF9, 32'd2, 1'b0, eq, er, edz);
        do_op(32'hFFFF_FFF9, 32'd2, 1'b0, q, r, dz, lat, bok, da, ba);
        tests_run++;
        if (q !== eq || r !== er || dz !== edz) begin
            tests_failed++;
            $display("FAIL udiv_fff9_2: q=%h r=%h dz=%b expected q=%h r=%h dz=%b", q, r, dz, eq, er, edz);
        end
    endtask

    task automatic test_div_zero();
        logic [W-1:0] q, r, eq, er;
        logic dz, edz, bok, da, ba;
        int lat;
        for (int s = 0; s < 2; s++) begin
            model(32'h1234, 32'd0, s[0], eq, er, edz);
            do_op(32'h1234, 32'd0, s[0], q, r, dz, lat, bok, da, ba);
            tests_run++;
            if (q !== eq || r !== er || dz !== edz) begin
                tests_failed++;
                $display("FAIL divzero_s%0d: q=%h r=%h dz=%b expected q=%h r=%h dz=%b", s, q, r, dz, eq, er, edz);
            end
            tests_run++;
            if (lat !== 2 || da !== 1'b0) begin
                tests_failed++;
                $display("FAIL divzero_latency_s%0d: lat=%0d done_after=%b expected lat=2 done_after=0", s, lat, da);
            end
        end
        // A normal divide must clear the sticky-looking flag.
        model(32'd9, 32'd3, 1'b0, eq, er, edz);
        do_op(32'd9, 32'd3, 1'b0, q, r, dz, lat, bok, da, ba);
        tests_run++;
        if (dz !== 1'b0 || q !== eq || r !== er) begin
            tests_failed++;
            $display("FAIL divzero_clear: q=%0d r=%0d dz=%b expected q=%0d r=%0d dz=0", q, r, dz, eq, er);
        end
    endtask

    task automatic test_overflow();
        logic [W-1:0] q, r, eq, er;
        logic dz, edz, bok, da, ba;
        int lat;
        model(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, eq, er, edz);
        do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, q, r, dz, lat, bok, da, ba);
        tests_run++;
        if (q !== eq || r !== er || dz !== edz) begin
            tests_failed++;
            $display("FAIL sdiv_min_m1: q=%h r=%h dz=%b expected q=%h r=%h dz=%b", q, r, dz, eq, er, edz);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, q, r, eq, er;
        logic s, dz, edz, bok, da, ba;
        int lat, elat, bad;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            s = $urandom_range(0, 1);
            case ($urandom_range(0, 7))
                0:       b = '0;
                1, 2:    b = $urandom_range(1, 15);
                3:       b = -($urandom_range(1, 15));
                4:       begin b = $urandom; a = $urandom_range(0, 3); end
                default: b = $urandom;
            endcase
            model(a, b, s, eq, er, edz);
            elat = (b == 0) ? 2 : W + 3;
            do_op(a, b, s, q, r, dz, lat, bok, da, ba);
            tests_run++;
            if (q !== eq || r !== er || dz !== edz || lat !== elat || !bok || da) begin
                tests_failed++;
                $display("FAIL random_%0d: a=%h b=%h s=%b got q=%h r=%h dz=%b lat=%0d expected q=%h r=%h dz=%b lat=%0d",
                         i, a, b, s, q, r, dz, lat, eq, er, edz, elat);
            end
        end
    endtask

    task automatic test_flush();
        logic [W-1:0] q, r, eq, er, nq, nr;
        logic dz, edz, ndz, bok, da, ba, seen_done;
        int lat;
        model(32'd1000, 32'd3, 1'b0, eq, er, edz);
        do_op(32'd1000, 32'd3, 1'b0, q, r, dz, lat, bok, da, ba);
        // Start another op, then flush during its 10th ITER cycle (edge k+11).
        @(negedge clk);
        bus.start     = 1'b1;
        bus.is_signed = 1'b0;
        bus.dividend  = 32'd77777;
        bus.divisor   = 32'd5;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        bus.flush = 1'b1;
        @(posedge clk);
        #1 bus.flush = 1'b0;
        tests_run++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_idle: busy=%b done=%b expected 0 0", bus.busy, bus.done);
        end
        seen_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) seen_done = 1'b1;
        end
        tests_run++;
        if (seen_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_no_done: done observed after flush, expected none");
        end
        tests_run++;
        if (bus.quotient !== eq || bus.remainder !== er || bus.div_by_zero !== edz) begin
            tests_failed++;
            $display("FAIL flush_hold: q=%0d r=%0d expected q=%0d r=%0d", bus.quotient, bus.remainder, eq, er);
        end
        // Flush together with start in IDLE: nothing starts.
        @(negedge clk);
        bus.start = 1'b1;
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        tests_run++;
        if (bus.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_beats_start: busy=%b expected 0", bus.busy);
        end
        model(32'd77777, 32'd5, 1'b0, nq, nr, ndz);
        do_op(32'd77777, 32'd5, 1'b0, q, r, dz, lat, bok, da, ba);
        tests_run++;
        if (q !== nq || r !== nr || dz !== ndz || lat !== W + 3) begin
            tests_failed++;
            $display("FAIL flush_restart: q=%0d r=%0d lat=%0d expected q=%0d r=%0d lat=%0d", q, r, lat, nq, nr, W + 3);
        end
    endtask

    task automatic test_reset_mid_and_held_start();
        logic [W-1:0] q, r, eq, er;
        logic dz, edz, bok, da, ba, seen_done;
        int lat;
        do_op(32'd500, 32'd9, 1'b0, q, r, dz, lat, bok, da, ba);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.is_signed = 1'b0;
        bus.dividend  = 32'hDEAD_BEEF;
        bus.divisor   = 32'd13;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (12) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({bus.busy, bus.done, bus.div_by_zero} !== 3'b000 || bus.quotient !== '0 || bus.remainder !== '0) begin
            tests_failed++;
            $display("FAIL reset_mid: busy=%b done=%b dbz=%b q=%h r=%h expected all 0",
                     bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        // First start after reset, held high for the whole operation with changing operands.
        model(32'd100, 32'd7, 1'b0, eq, er, edz);
        bus.start     = 1'b1;
        bus.is_signed = 1'b0;
        bus.dividend  = 32'd100;
        bus.divisor   = 32'd7;
        @(posedge clk);
        #1;
        bus.dividend = 32'd5;
        bus.divisor  = 32'd5;
        lat       = -1;
        seen_done = 1'b0;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (bus.done) begin
                lat = n;
                seen_done = 1'b1;
                break;
            end
        end
        q = bus.quotient;
        r = bus.remainder;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        tests_run++;
        if (q !== eq || r !== er || lat !== W + 3 || !seen_done) begin
            tests_failed++;
            $display("FAIL held_start: q=%0d r=%0d lat=%0d expected q=%0d r=%0d lat=%0d", q, r, lat, eq, er, W + 3);
        end
        tests_run++;
        if (bus.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL held_start_idle: busy=%b expected 0", bus.busy);
        end
    endtask

    initial begin
        tests_run     = 0;
        tests_failed  = 0;
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.is_signed = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        bus.flush     = 1'b0;
        test_reset();
        test_unsigned_basic();
        test_signed_modes();
        test_div_zero();
        test_overflow();
        test_random();
        test_flush();
        test_reset_mid_and_held_start();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
